// File: rtl/cr_cdc_handshake_tx.sv
// Source half of a two-phase req/ack clock-domain-crossing handshake.
// Holds one word on xfer_data per req toggle until the synchronized ack echoes it.
module cr_cdc_handshake_tx #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack,
    output logic             xfer_done,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
    localparam bit            TO_EN  = (TIMEOUT_CYCLES > 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                 state_q;
    logic                   in_ready_q;
    logic                   req_q;
    logic [WIDTH-1:0]       data_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   tmo_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;

    assign ack_s       = sync_q[SYNC_STAGES-1];
    assign in_ready    = in_ready_q;
    assign xfer_req    = req_q;
    assign xfer_data   = data_q;
    assign xfer_done   = done_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;

    // Next value of the WAIT-cycle counter.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
    end

    // Shift the asynchronous ack through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], xfer_ack};
        end
    end

    // Handshake FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            req_q      <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        data_q     <= in_data;
                        req_q      <= ~req_q;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (ack_s == req_q) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (TO_EN && (cnt_q != TO_MAX)) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TO_MAX) begin
                            tmo_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr_cdc_handshake_tx.sv
// Directed bench for cr_cdc_handshake_tx.
// Stimulus is driven and outputs sampled 1 time unit after each rising edge.
module tb_cr_cdc_handshake_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        xfer_req;
    logic [31:0] xfer_data;
    logic        xfer_ack;
    logic        xfer_done;
    logic        busy;
    logic        timeout_err;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cr_cdc_handshake_tx #(
        .WIDTH         (32),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .xfer_req   (xfer_req),
        .xfer_data  (xfer_data),
        .xfer_ack   (xfer_ack),
        .xfer_done  (xfer_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit seen,
                             output bit tmo);
        seen = 1'b0;
        tmo  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (timeout_err) tmo = 1'b1;
            if (xfer_done) seen = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] w [4];
        logic        exp_req;
        int          ndone;
        bit          seen;
        bit          tmo;

        w[0] = 32'hA1A1_A1A1;
        w[1] = 32'hA2A2_A2A2;
        w[2] = 32'hA3A3_A3A3;
        w[3] = 32'hA4A4_A4A4;

        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        xfer_ack = 1'b0;

        // reset held 3 edges with in_valid high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ctl", 32'({in_ready, xfer_req, xfer_done,
                                busy, timeout_err}), 32'h0);
            chk("rst_data", xfer_data, 32'h0);
        end
        rst = 1'b0;
        step();
        chk("rel_ready", 32'(in_ready), 32'h1);
        chk("rel_req", 32'(xfer_req), 32'h0);
        chk("rel_busy", 32'(busy), 32'h0);
        in_valid = 1'b0;

        // single transfer, done exactly 3 edges after ack toggle
        in_data  = 32'hCAFE_F00D;
        in_valid = 1'b1;
        step();
        chk("s_data", xfer_data, 32'hCAFE_F00D);
        chk("s_req", 32'(xfer_req), 32'h1);
        chk("s_busy", 32'(busy), 32'h1);
        chk("s_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        xfer_ack = 1'b1;
        step();
        chk("s_done1", 32'(xfer_done), 32'h0);
        step();
        chk("s_done2", 32'(xfer_done), 32'h0);
        chk("s_ready2", 32'(in_ready), 32'h0);
        step();
        chk("s_done3", 32'(xfer_done), 32'h1);
        chk("s_ready3", 32'(in_ready), 32'h1);
        chk("s_busy3", 32'(busy), 32'h0);
        step();
        chk("s_done4", 32'(xfer_done), 32'h0);

        // data stays frozen while in_data churns during WAIT
        in_data  = 32'h1111_1111;
        in_valid = 1'b1;
        step();
        chk("h_data", xfer_data, 32'h1111_1111);
        chk("h_req", 32'(xfer_req), 32'h0);
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hDEAD_0000 + 32'(i);
            step();
            chk("h_hold", xfer_data, 32'h1111_1111);
            chk("h_reqh", 32'(xfer_req), 32'h0);
        end
        in_valid = 1'b0;
        xfer_ack = 1'b0;
        wait_done(10, seen, tmo);
        chk("h_done", 32'(seen), 32'h1);
        chk("h_after", xfer_data, 32'h1111_1111);

        // back-to-back words; ack at 5 cycles lands on the timeout edge
        exp_req  = 1'b0;
        ndone    = 0;
        in_valid = 1'b1;
        in_data  = w[0];
        for (int k = 0; k < 4; k++) begin
            step();
            exp_req = ~exp_req;
            chk("b_data", xfer_data, w[k]);
            chk("b_req", 32'(xfer_req), 32'(exp_req));
            repeat (5) step();
            xfer_ack = exp_req;
            if (k < 3) in_data = w[k+1];
            wait_done(10, seen, tmo);
            if (seen) ndone++;
            chk("b_tmo", 32'(tmo), 32'h0);
        end
        in_valid = 1'b0;
        chk("b_ndone", 32'(ndone), 32'd4);
        chk("b_reqend", 32'(xfer_req), 32'h0);

        // reset two cycles into WAIT
        in_data  = 32'h0BAD_BEEF;
        in_valid = 1'b1;
        step();
        chk("r_req", 32'(xfer_req), 32'h1);
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("r_req0", 32'(xfer_req), 32'h0);
        chk("r_ready0", 32'(in_ready), 32'h0);
        chk("r_busy0", 32'(busy), 32'h0);
        chk("r_data0", xfer_data, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("r_ready1", 32'(in_ready), 32'h1);
        in_data  = 32'h600D_D00D;
        in_valid = 1'b1;
        step();
        chk("r_req1", 32'(xfer_req), 32'h1);
        chk("r_data1", xfer_data, 32'h600D_D00D);
        in_valid = 1'b0;
        xfer_ack = 1'b1;
        wait_done(10, seen, tmo);
        chk("r_done", 32'(seen), 32'h1);
        chk("r_ready2", 32'(in_ready), 32'h1);

        // timeout after 8 WAIT cycles, then late ack completes
        in_data  = 32'h5555_AAAA;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t_req", 32'(xfer_req), 32'h0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("t_err", 32'(timeout_err), 32'(i == 8));
            chk("t_busy", 32'(busy), 32'h1);
        end
        xfer_ack = 1'b0;
        wait_done(10, seen, tmo);
        chk("t_done", 32'(seen), 32'h1);
        chk("t_noerr", 32'(tmo), 32'h0);
        chk("t_data", xfer_data, 32'h5555_AAAA);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
